// File: rtl/seg_pkg.sv
// Shared constants and types for the segment-bus capture path: active-high
// segment patterns (bit0=a .. bit6=g), the blank code and the capture FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_HOLD
  } seg_state_t;

endpackage

// File: rtl/seg_capture_if.sv
// Multiplexed segment bus plus the recovered-digit outputs of seg_capture.
// The master side drives the bus; seg_capture sits on the slave side.
interface seg_capture_if #(
  parameter int NUM_DIGITS = 4
);

  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic                    err_clr;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    update;
  logic                    pattern_err;

  modport master (
    output seg_in, an_in, err_clr,
    input  digits_out, digit_valid, update, pattern_err
  );

  modport slave (
    input  seg_in, an_in, err_clr,
    output digits_out, digit_valid, update, pattern_err
  );

endinterface

// File: rtl/seg_to_code.sv
// Combinational decoder from a 7-segment pattern to its BCD code; blank maps to
// BLANK_CODE and any pattern outside the table is reported as illegal.
module seg_to_code
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_legal,
  output logic [3:0] o_code
);

  always_comb begin
    o_legal = 1'b1;
    o_code  = BLANK_CODE;
    case (i_seg)
      SEG_0:     o_code = 4'd0;
      SEG_1:     o_code = 4'd1;
      SEG_2:     o_code = 4'd2;
      SEG_3:     o_code = 4'd3;
      SEG_4:     o_code = 4'd4;
      SEG_5:     o_code = 4'd5;
      SEG_6:     o_code = 4'd6;
      SEG_7:     o_code = 4'd7;
      SEG_8:     o_code = 4'd8;
      SEG_9:     o_code = 4'd9;
      SEG_BLANK: o_code = BLANK_CODE;
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Recovers per-digit BCD values from a multiplexed segment bus, capturing only
// after STABLE_CYCLES identical samples. Define SEG_CAPTURE_ERR_EN for pattern_err.
module seg_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  seg_capture_if.slave   bus
);

  localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_CAP = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [6:0]              r_s_seg, r_p_seg;
  logic [NUM_DIGITS-1:0]   r_s_an, r_p_an;
  seg_state_t              r_state, w_next_state;
  logic [CNT_W-1:0]        r_cnt, w_next_cnt;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic                    r_update;
  logic                    r_err;

  logic                    w_legal;
  logic [3:0]              w_code;
  logic                    w_same;
  logic                    w_one_hot;
  logic                    w_capture;
  logic                    w_illegal_hit;

  seg_to_code u_decode (
    .i_seg   (r_s_seg),
    .o_legal (w_legal),
    .o_code  (w_code)
  );

  assign w_same    = ({r_s_seg, r_s_an} == {r_p_seg, r_p_an});
  assign w_one_hot = (r_s_an != '0) && ((r_s_an & (r_s_an - 1'b1)) == '0);

  // Capture fires on the edge where the matching-sample count would reach STABLE_CYCLES.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_capture     = 1'b0;
    w_illegal_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_cnt = '0;
        if (w_one_hot) begin
          w_next_state = ST_TRACK;
          w_next_cnt   = CNT_ONE;
        end
      end
      ST_TRACK: begin
        if (!w_one_hot) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else if (!w_same) begin
          w_next_cnt = CNT_ONE;
        end else if (r_cnt == CNT_CAP) begin
          w_next_state  = ST_HOLD;
          w_next_cnt    = CNT_MAX;
          w_capture     = w_legal;
          w_illegal_hit = !w_legal;
        end else if (r_cnt != CNT_MAX) begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!w_same) begin
          w_next_state = w_one_hot ? ST_TRACK : ST_IDLE;
          w_next_cnt   = w_one_hot ? CNT_ONE : '0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_seg  <= '0;
      r_p_seg  <= '0;
      r_s_an   <= '0;
      r_p_an   <= '0;
      r_digits <= {NUM_DIGITS{BLANK_CODE}};
      r_valid  <= '0;
      r_update <= 1'b0;
    end else begin
      r_s_seg  <= bus.seg_in;
      r_p_seg  <= r_s_seg;
      r_s_an   <= bus.an_in;
      r_p_an   <= r_s_an;
      r_update <= w_capture;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && r_s_an[i]) begin
          r_digits[4*i +: 4] <= w_code;
          r_valid[i]         <= 1'b1;
        end
      end
    end
  end

`ifdef SEG_CAPTURE_ERR_EN
  // A new error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_illegal_hit) begin
      r_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
    end
  end
`else
  logic w_unused_err;
  assign w_unused_err = bus.err_clr | w_illegal_hit;
  assign r_err        = 1'b0;
`endif

  assign bus.digits_out  = r_digits;
  assign bus.digit_valid = r_valid;
  assign bus.update      = r_update;
  assign bus.pattern_err = r_err;

endmodule

// File: tb/tb_seg_capture.sv
// Randomized scoreboard bench for seg_capture: a run-level reference model
// predicts each capture/error and a monitor checks the DUT every cycle.
module tb_seg_capture;

  localparam int ND = 4;
  localparam int SC = 4;

  typedef struct {
    int         cyc;
    int         slot;
    logic [3:0] code;
  } cap_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seg_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg_capture #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] segTab [11] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                              7'h7D, 7'h07, 7'h7F, 7'h67, 7'h00};

  cap_t capQ[$];
  int   errQ[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   updCount = 0;

  logic [4*ND-1:0] expDigits;
  logic [ND-1:0]   expValid;
  logic            expErr;

  logic [6:0]      lastSeg;
  logic [ND-1:0]   lastAn;
  int              runStart;
  int              runLen;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns {legal, code} straight from the pattern table.
  function automatic logic [4:0] refDecode(input logic [6:0] s);
    for (int i = 0; i < 11; i++) begin
      if (segTab[i] == s) return {1'b1, (i < 10) ? 4'(i) : 4'hF};
    end
    return {1'b0, 4'h0};
  endfunction

  // Model rule: a one-hot strobe with an unchanged pattern present for SC
  // consecutive edges starting at edge k produces its event at edge k+SC.
  task automatic driveCycle(input logic [ND-1:0] an, input logic [6:0] seg, input logic clr);
    logic [4:0] dec;
    int slot;
    @(negedge clk);
    reset       = 1'b0;
    bus.an_in   = an;
    bus.seg_in  = seg;
    bus.err_clr = clr;
    if ({an, seg} != {lastAn, lastSeg}) begin
      runStart = cyc + 1;
      runLen   = 0;
      lastAn   = an;
      lastSeg  = seg;
    end
    runLen++;
    if (runLen == SC && $countones(an) == 1) begin
      slot = 0;
      for (int i = 0; i < ND; i++) if (an[i]) slot = i;
      dec = refDecode(seg);
      if (dec[4]) capQ.push_back('{runStart + SC, slot, dec[3:0]});
      else        errQ.push_back(runStart + SC);
    end
  endtask

  task automatic applyStimulus(input logic [ND-1:0] an, input logic [6:0] seg, input int len,
                               input bit rndClr);
    for (int c = 0; c < len; c++) begin
      driveCycle(an, seg, rndClr && ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    reset       = 1'b1;
    bus.an_in   = '0;
    bus.seg_in  = '0;
    bus.err_clr = 1'b0;
    capQ.delete();
    errQ.delete();
    lastAn  = '0;
    lastSeg = '0;
    runLen  = 0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on each update and compares outputs every cycle.
  always @(posedge clk) begin : monitor
    logic clrNow;
    logic rstNow;
    cap_t e;
    cyc++;
    clrNow = bus.err_clr;
    rstNow = reset;
    #1;
    if (rstNow) begin
      expDigits = {ND{4'hF}};
      expValid  = '0;
      expErr    = 1'b0;
      checkOutput("reset_update", 32'(bus.update), 32'(0));
    end else begin
      while (capQ.size() > 0 && capQ[0].cyc < cyc) begin
        checkOutput("capture_missed", 32'(cyc), 32'(capQ[0].cyc));
        void'(capQ.pop_front());
      end
      if (bus.update) begin
        updCount++;
        if (capQ.size() == 0) begin
          checkOutput("update_unexpected", 32'(bus.update), 32'(0));
        end else begin
          e = capQ.pop_front();
          checkOutput("update_cycle", 32'(cyc), 32'(e.cyc));
          expDigits[4*e.slot +: 4] = e.code;
          expValid[e.slot]         = 1'b1;
        end
      end
      while (errQ.size() > 0 && errQ[0] < cyc) void'(errQ.pop_front());
      if (errQ.size() > 0 && errQ[0] == cyc) begin
        void'(errQ.pop_front());
`ifdef SEG_CAPTURE_ERR_EN
        expErr = 1'b1;
`endif
      end else if (clrNow) begin
        expErr = 1'b0;
      end
    end
    checkOutput("digits_out", 32'(bus.digits_out), 32'(expDigits));
    checkOutput("digit_valid", 32'(bus.digit_valid), 32'(expValid));
    checkOutput("pattern_err", 32'(bus.pattern_err), 32'(expErr));
  end

  initial begin : stimulus
    int base;
    logic [ND-1:0] an;
    logic [6:0] seg;
    bus.an_in   = '0;
    bus.seg_in  = '0;
    bus.err_clr = 1'b0;
    lastAn      = '0;
    lastSeg     = '0;
    runStart    = 0;
    runLen      = 0;
    doReset(3);

    base = updCount;
    applyStimulus(4'b0001, 7'h5B, 10, 1'b0);
    checkOutput("t1_digit0", 32'(bus.digits_out[3:0]), 32'(2));
    checkOutput("t1_valid", 32'(bus.digit_valid), 32'(4'b0001));
    checkOutput("t1_updates", 32'(updCount - base), 32'(1));

    base = updCount;
    applyStimulus(4'b0001, 7'h7F, 6, 1'b0);
    applyStimulus(4'b0010, 7'h06, 6, 1'b0);
    applyStimulus(4'b0100, 7'h00, 6, 1'b0);
    applyStimulus(4'b1000, 7'h67, 6, 1'b0);
    checkOutput("scan_value", 32'(bus.digits_out), 32'(16'h9F18));
    checkOutput("scan_valid", 32'(bus.digit_valid), 32'(4'b1111));
    checkOutput("scan_updates", 32'(updCount - base), 32'(4));

    base = updCount;
    for (int t = 0; t < 8; t++) applyStimulus(4'b0010, (t % 2 == 0) ? 7'h4F : 7'h66, 3, 1'b0);
    checkOutput("toggle_value", 32'(bus.digits_out), 32'(16'h9F18));
    checkOutput("toggle_updates", 32'(updCount - base), 32'(0));

    base = updCount;
    applyStimulus(4'b0100, 7'h49, 8, 1'b0);
`ifdef SEG_CAPTURE_ERR_EN
    checkOutput("illegal_err", 32'(bus.pattern_err), 32'(1));
`else
    checkOutput("illegal_err", 32'(bus.pattern_err), 32'(0));
`endif
    checkOutput("illegal_slot", 32'(bus.digits_out[11:8]), 32'(4'hF));
    checkOutput("illegal_updates", 32'(updCount - base), 32'(0));
    driveCycle('0, 7'h00, 1'b1);
    driveCycle('0, 7'h00, 1'b0);
    checkOutput("err_cleared", 32'(bus.pattern_err), 32'(0));

    base = updCount;
    applyStimulus(4'b0011, 7'h3F, 20, 1'b0);
    checkOutput("multihot_updates", 32'(updCount - base), 32'(0));

    base = updCount;
    applyStimulus(4'b0001, 7'h06, 3, 1'b0);
    doReset(2);
    checkOutput("rst_digits", 32'(bus.digits_out), 32'(16'hFFFF));
    checkOutput("rst_valid", 32'(bus.digit_valid), 32'(0));
    checkOutput("rst_updates", 32'(updCount - base), 32'(0));
    applyStimulus(4'b0001, 7'h06, 8, 1'b0);
    checkOutput("post_rst_digit0", 32'(bus.digits_out[3:0]), 32'(1));
    checkOutput("post_rst_updates", 32'(updCount - base), 32'(1));

    for (int r = 0; r < 150; r++) begin
      case ($urandom_range(0, 9))
        0:       an = '0;
        1:       an = ND'($urandom);
        default: an = ND'(1) << $urandom_range(0, ND - 1);
      endcase
      seg = ($urandom_range(0, 4) == 0) ? 7'($urandom) : segTab[$urandom_range(0, 10)];
      if ($urandom_range(0, 29) == 0) doReset(1);
      applyStimulus(an, seg, $urandom_range(1, SC + 3), 1'b1);
    end

    applyStimulus('0, 7'h00, SC + 3, 1'b0);
    checkOutput("queue_empty", 32'(capQ.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
